// File: rtl/mem_loader_ram_if.sv
// Byte-stream handshake feeding mem_loader_ram: 8-bit data with valid/ready.
interface mem_loader_ram_if;
  logic [7:0] byteIn;
  logic       byteValid;
  logic       byteReady;

  modport master (output byteIn, output byteValid, input  byteReady);
  modport slave  (input  byteIn, input  byteValid, output byteReady);
endinterface

// File: rtl/mem_loader_ram.sv
// Packs a little-endian byte stream into words written sequentially into a
// small register array, exposing two asynchronous read ports for the ALU.
module mem_loader_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   startAddr,
  input  logic [ADDR_W:0]     wordCount,
  mem_loader_ram_if.slave     stream,
  output logic                busy,
  output logic                done,
  input  logic [ADDR_W-1:0]   addressA,
  input  logic [ADDR_W-1:0]   addressB,
  output logic [DATA_W-1:0]   dataA,
  output logic [DATA_W-1:0]   dataB
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(DEPTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [CNT_W-1:0]    count_c;
  logic [DATA_W-1:0]   word_c;
  logic                accept_c;

  // Requests above the array depth load the whole array once.
  assign count_c = (wordCount > MAX_CNT) ? MAX_CNT : wordCount;

  assign accept_c = stream.byteValid && (state_q == S_LOAD);

  // Assembly register with the incoming byte merged into its lane.
  always_comb begin
    word_c = asm_q;
    word_c[{lane_q, 3'b000} +: 8] = stream.byteIn;
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    mem_d   = mem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count_c != '0) begin
            state_d = S_LOAD;
            ptr_d   = startAddr;
            rem_d   = count_c;
            lane_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (accept_c) begin
          asm_d = word_c;
          if (lane_q == LAST_LANE) begin
            mem_d[ptr_q] = word_c;
            lane_d       = '0;
            ptr_d        = ptr_q + ADDR_W'(1);
            rem_d        = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = S_DONE;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // Reset wins over any in-flight write, so an aborted load leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      mem_q   <= '{default: '0};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      mem_q   <= mem_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stream.byteReady = ready_q;
  assign busy             = busy_q;
  assign done             = done_q;

  // Read ports see only committed array contents; no bypass of the write.
  assign dataA = mem_q[addressA];
  assign dataB = mem_q[addressB];

endmodule

// File: doc/mem_loader_ram.md
Name: mem_loader_ram

Overview:
- Write-side counterpart to the ALU's dual-read operand memory.
- Accepts a byte stream over a valid/ready handshake and packs each 4 bytes into a 32-bit word, little-endian.
- Writes the words sequentially into an internal 16x32 array.
- Exposes the same two asynchronous read ports (addressA/dataA, addressB/dataB) so the ALU datapath reads operands directly.

Parameters:
- DATA_W, 32, word width; must be a multiple of 8.
- ADDR_W, 4, address width.
- DEPTH, 16, number of words; equals 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle load request; sampled only in IDLE.
- startAddr  input  ADDR_W  first word address of the load.
- wordCount  input  ADDR_W+1  number of words to load, 0..16; values above 16 are clamped to 16.
- byteIn  input  8  stream data.
- byteValid  input  1  byteIn is valid.
- byteReady  output  1  block accepts a byte this cycle.
- busy  output  1  high while not in IDLE.
- done  output  1  one-cycle pulse when the load completes.
- addressA  input  ADDR_W  read port A address.
- addressB  input  ADDR_W  read port B address.
- dataA  output  DATA_W  memory[addressA], combinational.
- dataB  output  DATA_W  memory[addressB], combinational.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - All 16 memory words clear to 0, so dataA = dataB = 0.
  - byteReady=0, busy=0, done=0.
  - Write pointer, byte lane and assembly register clear to 0.
  - Reset mid-load aborts the load: any partial word is discarded and no write occurs on the reset edge.
- States are IDLE, LOAD and DONE.
- IDLE:
  - byteReady=0, busy=0.
  - start=1 with clamped count != 0 moves to LOAD: ptr<=startAddr, remaining<=count, lane<=0.
  - start=1 with count == 0 moves straight to DONE; nothing is written.
- LOAD:
  - byteReady=1 and busy=1.
  - A byte is accepted when byteValid && byteReady at the edge.
  - An accepted byte goes into assembly lane `lane`: bits [8*lane+7 : 8*lane]. lane then increments.
  - On the 4th accepted byte (lane==3), memory[ptr] <= {byteIn, asm[23:0]} at that same edge. Then lane<=0, ptr<=ptr+1 mod 16 (wraps 15 to 0), remaining<=remaining-1.
  - When remaining reaches 0, the next state is DONE.
  - byteValid=0 stalls the load indefinitely with no state change.
  - start is ignored in LOAD.
- DONE:
  - done=1, byteReady=0, busy=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE.
- Read ports:
  - Purely combinational from the array.
  - A word written at edge N appears on dataA/dataB after edge N, never before (no write-through bypass).
  - addressA == addressB is legal; both ports return the same word.
- A load of 16 words starting at a nonzero address wraps and overwrites from address 0 onward. This is legal and not flagged.
- Words not targeted by a load keep their previous contents.
- Latency: first byte accepted in the cycle after start is seen. Word k is visible on the read ports the cycle after its 4th byte is accepted. done asserts the cycle after the final byte.

Test Plan:
1. Reset, then any addressA/addressB -> dataA=dataB=32'h0, byteReady=0, busy=0, done=0.
2. start with startAddr=2, wordCount=2, then bytes 11,22,33,44,55,66,77,88 with byteValid held high:
   - memory[2]=32'h44332211 and memory[3]=32'h88776655.
   - done pulses one cycle after byte 88.
   - Reading with addressA=2, addressB=3 gives those values.
3. Same load as scenario 2 with byteValid toggled 1,0,1,0:
   - Identical final memory contents.
   - done is delayed by exactly the number of stall cycles.
4. startAddr=15, wordCount=2, bytes 01..08 -> memory[15]=32'h04030201, memory[0]=32'h08070605, memory[1] unchanged.
5. start with wordCount=0 -> done pulses in the next cycle, busy high for that one cycle, byteReady never asserts, memory unchanged.
6. Assert rst after 6 bytes of a 2-word load to address 4:
   - memory[4] reads 0 because reset clears the array.
   - State is IDLE; a following new load completes normally.
7. start pulsed again during LOAD -> ignored; the original load finishes with its original count.
